// File: rtl/sprite_blitter.sv
// sprite_blitter: walks one SPR_W x SPR_H sprite out of a synchronous sprite
// ROM and turns each texel into a screen-space pixel write. Transparent texels
// and pixels that land outside the screen are dropped. Throughput is one texel
// per clock.
//
// Ports
//   clk, resetn           clock, asynchronous active-low reset
//   start                 begin a blit (only honoured while idle)
//   sprite_id/x_org/y_org sprite index and screen origin, latched on start
//   rom_addr / rom_data   sprite ROM address out, texel in (ROM_LAT later)
//   vga_x/vga_y/vga_colour/vga_plot  pixel write to the VGA adapter
//   busy                  blit in progress
//   done                  one-cycle completion pulse
module sprite_blitter #(
    parameter int SPR_W    = 47,
    parameter int SPR_H    = 52,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int ADDR_W   = 16,
    parameter int ID_W     = 4,
    parameter int COLOR_W  = 9,
    parameter int ROM_LAT  = 1,
    parameter logic [COLOR_W-1:0] TRANSP = 9'h1FF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [ID_W-1:0]    sprite_id,
    input  logic [X_W-1:0]     x_org,
    input  logic [Y_W-1:0]     y_org,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [X_W-1:0]     vga_x,
    output logic [Y_W-1:0]     vga_y,
    output logic [COLOR_W-1:0] vga_colour,
    output logic               vga_plot,
    output logic               busy,
    output logic               done
);

    localparam int N   = SPR_W * SPR_H;
    localparam int CXW = $clog2(SPR_W + 1);
    localparam int CYW = $clog2(SPR_H + 1);
    localparam int FCW = $clog2(ROM_LAT + 1);

    typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

    // Screen coordinate of one texel, one bit wider than the screen fields so
    // that a sum which wraps past the edge stays visibly off-screen.
    typedef struct packed {
        logic [X_W:0] x;
        logic [Y_W:0] y;
    } coord_t;

    state_t state, nstate;

    logic [CXW-1:0] cx;
    logic [CYW-1:0] cy;
    logic [FCW-1:0] fcnt;
    logic [X_W-1:0] xo;
    logic [Y_W-1:0] yo;
    logic           last_px, flush_end;

    // Stage 0 is aligned with rom_addr; stage ROM_LAT lines up with rom_data.
    logic                 vld0;
    coord_t               crd0;
    logic   [ROM_LAT:1]   vld_pipe;
    coord_t [ROM_LAT:1]   crd_pipe;
    coord_t               tail;

    assign last_px   = (cx == CXW'(SPR_W - 1)) && (cy == CYW'(SPR_H - 1));
    assign flush_end = (fcnt == FCW'(ROM_LAT - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= nstate;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (start)     nstate = DRAW;
            DRAW:    if (last_px)   nstate = FLUSH;
            FLUSH:   if (flush_end) nstate = DONE;
            DONE:                   nstate = IDLE;
            default:                nstate = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state == DRAW) || (state == FLUSH);
        done = (state == DONE);
        vld0 = (state == DRAW);
    end

    // ---------------- Walk counters and address ----------------
    // The address simply counts up from the sprite base; the raster position
    // (cx, cy) is tracked alongside it only to form screen coordinates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rom_addr <= '0;
            cx       <= '0;
            cy       <= '0;
            fcnt     <= '0;
            xo       <= '0;
            yo       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    xo       <= x_org;
                    yo       <= y_org;
                    cx       <= '0;
                    cy       <= '0;
                    rom_addr <= ADDR_W'(sprite_id) * ADDR_W'(N);
                end
                DRAW: begin
                    rom_addr <= rom_addr + 1'b1;
                    fcnt     <= '0;
                    if (cx == CXW'(SPR_W - 1)) begin
                        cx <= '0;
                        cy <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                FLUSH:   fcnt <= fcnt + 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- Coordinate / valid pipeline ----------------
    assign crd0.x = {1'b0, xo} + (X_W+1)'(cx);
    assign crd0.y = {1'b0, yo} + (Y_W+1)'(cy);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
            crd_pipe <= '0;
        end else begin
            vld_pipe[1] <= vld0;
            crd_pipe[1] <= crd0;
            for (int i = 2; i <= ROM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                crd_pipe[i] <= crd_pipe[i-1];
            end
        end
    end

    // ---------------- Pixel output ----------------
    // The colour comes straight from the ROM so a pixel leaves in the same
    // cycle its texel arrives; the pipeline tail holds the matching
    // coordinates. Outside a valid slot the colour is forced to zero.
    assign tail       = crd_pipe[ROM_LAT];
    assign vga_x      = tail.x[X_W-1:0];
    assign vga_y      = tail.y[Y_W-1:0];
    assign vga_colour = vld_pipe[ROM_LAT] ? rom_data : '0;
    assign vga_plot   = vld_pipe[ROM_LAT]
                     && (rom_data != TRANSP)
                     && (tail.x < (X_W+1)'(SCREEN_W))
                     && (tail.y < (Y_W+1)'(SCREEN_H));

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int L  = 1;
    localparam int N  = W * H;
    localparam int LB = 3;
    localparam int NB = 47 * 52;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    // small instance (4x3, latency 1)
    logic        start;
    logic [3:0]  sprite_id;
    logic [8:0]  x_org;
    logic [7:0]  y_org;
    logic [15:0] rom_addr;
    logic [8:0]  rom_data;
    logic [8:0]  vga_x, vga_colour;
    logic [7:0]  vga_y;
    logic        vga_plot, busy, done;
    // default-size instance with latency 3
    logic        start_b;
    logic [3:0]  id_b;
    logic [8:0]  xb;
    logic [7:0]  yb;
    logic [15:0] rom_addr_b;
    logic [8:0]  rom_data_b;
    logic [8:0]  vga_x_b, vga_colour_b;
    logic [7:0]  vga_y_b;
    logic        vga_plot_b, busy_b, done_b;

    sprite_blitter #(.SPR_W(W), .SPR_H(H), .ROM_LAT(L)) dut (
        .clk(clk), .resetn(resetn), .start(start), .sprite_id(sprite_id),
        .x_org(x_org), .y_org(y_org), .rom_addr(rom_addr), .rom_data(rom_data),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .done(done));

    sprite_blitter #(.ROM_LAT(LB)) dut_b (
        .clk(clk), .resetn(resetn), .start(start_b), .sprite_id(id_b),
        .x_org(xb), .y_org(yb), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .vga_x(vga_x_b), .vga_y(vga_y_b), .vga_colour(vga_colour_b), .vga_plot(vga_plot_b),
        .busy(busy_b), .done(done_b));

    // Model ROM: data = address, except address 5 which is transparent.
    function automatic logic [8:0] romf(input logic [15:0] a);
        return (a == 16'd5) ? 9'h1FF : a[8:0];
    endfunction

    logic [8:0] rb [0:2];
    always @(posedge clk) rom_data <= romf(rom_addr);
    always @(posedge clk) begin
        rb[0] <= romf(rom_addr_b);
        rb[1] <= rb[0];
        rb[2] <= rb[1];
    end
    assign rom_data_b = rb[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- Scoreboard ----------------
    typedef struct {
        int         c;
        logic [8:0] x;
        logic [7:0] y;
        logic [8:0] col;
    } pix_t;

    pix_t plot_q[$];
    bit   busy_m[int];
    bit   done_m[int];
    int   addr_m[int];
    bit   mon_en = 1'b0;

    // s = bench cycle in which start is driven; the DUT samples it at the
    // following edge, so relative cycle k of the blit is bench cycle s+k.
    task automatic expect_blit(input int s, input int id, input int xo, input int yo);
        for (int n = 0; n < N; n++) begin
            int px, py;
            logic [8:0] c9;
            px = xo + n % W;
            py = yo + n / W;
            c9 = romf(16'(id * N + n));
            addr_m[s + 1 + n] = id * N + n;
            busy_m[s + 1 + n] = 1'b1;
            if (c9 != 9'h1FF && px < 320 && py < 240)
                plot_q.push_back('{c: s + n + L + 1, x: 9'(px), y: 8'(py), col: c9});
        end
        for (int f = 1; f <= L; f++) busy_m[s + N + f] = 1'b1;
        done_m[s + N + L + 1] = 1'b1;
    endtask

    always @(negedge clk) begin
        logic ep;
        if (mon_en) begin
            ep = (plot_q.size() > 0) && (plot_q[0].c == cyc);
            chk("plot", vga_plot, ep);
            if (ep) begin
                if (vga_plot) begin
                    chk("vga_x", vga_x, plot_q[0].x);
                    chk("vga_y", vga_y, plot_q[0].y);
                    chk("colour", vga_colour, plot_q[0].col);
                end
                plot_q.delete(0);
            end
            chk("busy", busy, busy_m.exists(cyc));
            chk("done", done, done_m.exists(cyc));
            if (addr_m.exists(cyc)) chk("rom_addr", rom_addr, addr_m[cyc]);
        end
    end

    // ---------------- Stimulus ----------------
    // One blit; optionally pulses start again mid-DRAW, which must be ignored.
    task automatic blit(input int id, input int xo, input int yo, input bit glitch);
        int s;
        @(negedge clk);
        s = cyc;
        sprite_id = 4'(id); x_org = 9'(xo); y_org = 8'(yo); start = 1'b1;
        expect_blit(s, id, xo, yo);
        @(negedge clk);
        start = 1'b0;
        sprite_id = 4'($urandom); x_org = 9'($urandom); y_org = 8'($urandom);
        if (glitch) begin
            while (cyc < s + 4) @(negedge clk);
            start = 1'b1; sprite_id = 4'd3;
            @(negedge clk);
            start = 1'b0;
        end
        while (cyc < s + N + L + 1) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, s2, first, done_at, nplot, expn;
        resetn = 1'b0; start = 1'b0; sprite_id = '0; x_org = '0; y_org = '0;
        start_b = 1'b0; id_b = '0; xb = '0; yb = '0;
        repeat (3) @(negedge clk);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_vga_x", vga_x, 0);
        chk("rst_vga_y", vga_y, 0);
        chk("rst_colour", vga_colour, 0);
        chk("rst_plot", vga_plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        resetn = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // directed cases from the block's test plan
        blit(0, 10, 20, 1'b0);
        blit(2, 100, 50, 1'b0);
        blit(0, 318, 238, 1'b0);
        blit(0, 511, 255, 1'b0);
        blit(1, 40, 40, 1'b1);

        // start held high: second blit at the earliest legal edge
        @(negedge clk);
        s = cyc;
        sprite_id = 4'd0; x_org = 9'd5; y_org = 8'd6; start = 1'b1;
        s2 = s + N + L + 2;
        expect_blit(s, 0, 5, 6);
        expect_blit(s2, 0, 5, 6);
        while (cyc < s2 + 1) @(negedge clk);
        start = 1'b0;
        while (cyc < s2 + N + L + 1) @(negedge clk);

        // reset in cycle 6 of a blit
        @(negedge clk);
        s = cyc;
        sprite_id = 4'd0; x_org = 9'd10; y_org = 8'd20; start = 1'b1;
        expect_blit(s, 0, 10, 20);
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 5) @(negedge clk);
        @(posedge clk);
        #2;
        plot_q.delete(); busy_m.delete(); done_m.delete(); addr_m.delete();
        resetn = 1'b0;
        #1;
        chk("arst_rom_addr", rom_addr, 0);
        chk("arst_vga_x", vga_x, 0);
        chk("arst_vga_y", vga_y, 0);
        chk("arst_colour", vga_colour, 0);
        chk("arst_plot", vga_plot, 0);
        chk("arst_busy", busy, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        blit(0, 10, 20, 1'b0);

        // randomized blits, biased toward the screen edges
        for (int t = 0; t < 12; t++) begin
            int xo, yo;
            case ($urandom_range(0, 2))
                0:       xo = $urandom_range(0, 511);
                1:       xo = $urandom_range(314, 319);
                default: xo = $urandom_range(505, 511);
            endcase
            case ($urandom_range(0, 2))
                0:       yo = $urandom_range(0, 255);
                1:       yo = $urandom_range(236, 239);
                default: yo = $urandom_range(252, 255);
            endcase
            blit($urandom_range(0, 3), xo, yo, $urandom_range(0, 1) == 1);
        end
        repeat (4) @(negedge clk);
        chk("queue_empty", plot_q.size(), 0);

        // default-size sprite with a 3-cycle ROM
        @(negedge clk);
        s = cyc;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        first = -1; done_at = -1; nplot = 0;
        for (int k = 0; k < NB + 20; k++) begin
            if (vga_plot_b) begin
                int n;
                n = cyc - s - 4;
                if (first < 0) first = cyc - s;
                nplot++;
                chk("b_x", vga_x_b, 9'(n % 47));
                chk("b_y", vga_y_b, 8'(n / 47));
                chk("b_colour", vga_colour_b, romf(16'(n)));
            end
            if (done_b) begin
                done_at = cyc - s;
                break;
            end
            @(negedge clk);
        end
        expn = 0;
        for (int n = 0; n < NB; n++) if (romf(16'(n)) != 9'h1FF) expn++;
        chk("b_first_plot", first, 4);
        chk("b_done_cycle", done_at, NB + LB + 1);
        chk("b_plot_count", nplot, expn);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
